// File: rtl/dot_prod_engine.sv
// Pipelined signed dot product over a wrap-around window of two on-chip vector memories, with a host load/read port.
// Optional saturating accumulate when DOT_PROD_ENGINE_SAT_EN is defined; otherwise the add wraps and sat is tied 0.
`timescale 1ns/1ps
module dot_prod_engine #(
  parameter  int DATA_W = 27,
  parameter  int DEPTH  = 1000,
  parameter  int ACC_W  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] init_base,
  input  logic [ADDR_W:0]   init_len,
  input  logic [ACC_W-1:0]  init_acc,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              sat,
  input  logic              ctrl_sel,
  input  logic              ctrl_we_a,
  input  logic              ctrl_we_b,
  input  logic [ADDR_W-1:0] ctrl_addr_a,
  input  logic [ADDR_W-1:0] ctrl_addr_b,
  input  logic [DATA_W-1:0] ctrl_wdata_a,
  input  logic [DATA_W-1:0] ctrl_wdata_b,
  output logic [DATA_W-1:0] ctrl_rdata_a,
  output logic [DATA_W-1:0] ctrl_rdata_b
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0]   mem_a [DEPTH];
  logic signed [DATA_W-1:0]   mem_b [DEPTH];
  logic signed [DATA_W-1:0]   rd_a, rd_b;
  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [ACC_W-1:0]    prod_q, acc, acc_sum;
  logic [ADDR_W-1:0]          idx;
  logic [ADDR_W:0]            cnt, len_clamped;
  logic                       vld;
  logic                       host_en;
  logic                       accept;

  // Host owns the memories only while the engine is idle.
  assign host_en = ctrl_sel & ~busy;
  assign accept  = (state == S_IDLE) & start;

  always_ff @(posedge clk) begin
    if (host_en && ctrl_we_a && ctrl_addr_a <= LAST_IDX) mem_a[ctrl_addr_a] <= ctrl_wdata_a;
    if (host_en && ctrl_we_b && ctrl_addr_b <= LAST_IDX) mem_b[ctrl_addr_b] <= ctrl_wdata_b;
  end

  assign ctrl_rdata_a = (host_en && ctrl_addr_a <= LAST_IDX) ? mem_a[ctrl_addr_a] : '0;
  assign ctrl_rdata_b = (host_en && ctrl_addr_b <= LAST_IDX) ? mem_b[ctrl_addr_b] : '0;

  assign rd_a        = mem_a[idx];
  assign rd_b        = mem_b[idx];
  assign prod_full   = (2*DATA_W)'(rd_a) * (2*DATA_W)'(rd_b);
  assign len_clamped = (init_len > DEPTH_C) ? DEPTH_C : init_len;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len_clamped == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (cnt == ONE_C) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

`ifdef DOT_PROD_ENGINE_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] sum_raw;
  logic                    ovf;
  logic                    sat_flag;

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    sum_raw = acc + prod_q;
    ovf     = (acc[ACC_W-1] == prod_q[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
    acc_sum = sum_raw;
    if (ovf) acc_sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      sat      <= 1'b0;
    end else begin
      if (accept)          sat_flag <= 1'b0;
      else if (vld && ovf) sat_flag <= 1'b1;
      if (state == S_DONE) sat <= sat_flag;
    end
  end
`else
  assign acc_sum = acc + prod_q;
  assign sat     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      cnt    <= '0;
      acc    <= '0;
      prod_q <= '0;
      vld    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      vld  <= (state == S_RUN);
      done <= 1'b0;
      if (state == S_RUN) begin
        prod_q <= ACC_W'(prod_full);
        idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        cnt    <= cnt - ONE_C;
      end
      if (accept) begin
        idx  <= init_base;
        cnt  <= len_clamped;
        acc  <= init_acc;
        busy <= 1'b1;
      end else if (vld) begin
        acc <= acc_sum;
      end
      if (state == S_DONE) begin
        result <= acc;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dot_prod_engine.md
Name: dot_prod_engine

Overview:
- Parametrised successor of the single-shot dot-product core.
- Computes the signed dot product acc0 + sum a[i]*b[i] over a contiguous, wrap-around window of two on-chip vector memories.
- Pipelined to accept one element pair per cycle, with a start/busy/done handshake.
- A host port loads and reads both memories while the engine is idle.

Parameters:
- DATA_W, 27: signed element width of memories a and b.
- DEPTH, 1000: words per memory. ADDR_W = $clog2(DEPTH) is derived (localparam).
- ACC_W, 64: signed accumulator/result width; must be >= 2*DATA_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a run; sampled only in IDLE
- init_base  in  ADDR_W  first element index; must be < DEPTH
- init_len  in  ADDR_W+1  element count
- init_acc  in  ACC_W  signed initial accumulator value
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when result is valid
- result  out  ACC_W  final accumulator; held until the next done
- sat  out  1  result saturated (optional feature only)
- ctrl_sel  in  1  host owns the memory ports
- ctrl_we_a, ctrl_we_b  in  1  host write enables
- ctrl_addr_a, ctrl_addr_b  in  ADDR_W  host addresses
- ctrl_wdata_a, ctrl_wdata_b  in  DATA_W  host write data
- ctrl_rdata_a, ctrl_rdata_b  out  DATA_W  host read data, combinational

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state=IDLE; busy=0, done=0, sat=0; result=0; acc=0; pipeline valid bit=0.
  - Memory contents are not reset.
- Memories:
  - Write is synchronous. Read is asynchronous (mem[addr]).
  - The engine never writes either memory.
- Host port:
  - With ctrl_sel=1 and busy=0, host signals drive memory address, write enable and write data.
  - With busy=1, host writes are dropped and ctrl_rdata_* read 0.
  - With ctrl_sel=0, ctrl_rdata_* read 0.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE, start=1 at edge T:
    - idx<=init_base; cnt<=min(init_len, DEPTH); acc<=init_acc; busy<=1.
    - Next state is RUN, or DRAIN if the clamped length is 0.
  - RUN, each cycle:
    - Both memories are addressed by idx.
    - prod_q <= a*b (signed 2*DATA_W product, sign-extended to ACC_W); vld<=1.
    - idx <= (idx==DEPTH-1) ? 0 : idx+1 (wrap).
    - cnt <= cnt-1. Leave to DRAIN when cnt==1.
  - Accumulate in any state: if vld, acc <= acc + prod_q, wrapping modulo 2^ACC_W.
    - vld<=0 whenever not in RUN.
  - DRAIN: one cycle for the final accumulate.
  - DONE: result<=acc (registered); done=1 for this single cycle; busy<=0; next state IDLE.
- Latency:
  - done is high in cycle T+L+2, where L is the clamped length.
  - The next start is accepted in the cycle after done.
  - For L=0, result=init_acc at T+2.
- Boundary conditions:
  - start while busy: ignored.
  - init_len > DEPTH: clamped to DEPTH.
  - base+L crossing DEPTH: wraps to index 0.
  - Reset mid-run: aborts immediately; no done pulse.
  - ctrl_sel raised mid-run: has no effect on the run.

Optional Feature:
- Macro: DOT_PROD_ENGINE_SAT_EN.
- Defined:
  - The accumulate add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky flag is set on any clamp during a run and cleared at start.
  - sat <= flag together with result at DONE.
- Undefined: wrapping add; sat is tied 0.

Test Plan:
- Host loads a[i]=i, b[i]=2 for i<1000; start base=0, len=1000, acc=5 -> done at T+1002, result=999005, busy low after done.
- Host loads a[998]=-3, a[999]=4, a[0]=7 with b=-1 on those words; start base=998, len=3 -> wrap path exercised, result=-8 at T+5.
- Start with len=0, acc=-42 -> result=-42 at T+2; second start pulsed while busy -> ignored, exactly one done.
- Start with len=1023 -> clamped to 1000 and done at T+1002; host write with ctrl_sel=1 during the run -> memory unchanged afterwards, ctrl_rdata=0.
- ACC_W=54, a=b=-(2^26) over 4 elements, acc=2^53-2^52 -> macro defined: result=2^53-1, sat=1; undefined: wrapped value, sat=0.
- rst_n low at RUN cycle 10 -> all outputs 0 immediately, no done; a fresh start after release gives the correct result.
